// File: rtl/montgomery_precompute_pkg.sv
// Shared constants and FSM encoding for the Montgomery R / R^2 precompute block.
package montgomery_precompute_pkg;

  localparam int N_DEFAULT  = 512;
  localparam int CW_DEFAULT = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/montgomery_precompute_if.sv
// Start/done handshake and result bus between a requester and montgomery_precompute.
interface montgomery_precompute_if #(
  parameter int N = montgomery_precompute_pkg::N_DEFAULT
);
  logic         start;
  logic [N-1:0] in_m;
  logic [N-1:0] rmodm;
  logic [N-1:0] r2modm;
  logic         busy;
  logic         done;

  modport master (output start, in_m, input rmodm, r2modm, busy, done);
  modport slave  (input start, in_m, output rmodm, r2modm, busy, done);
endinterface

// File: rtl/montgomery_precompute_mod_double.sv
// Combinational modular doubling: y = 2a mod m, valid for a < m.
module mod_double #(
  parameter int N = montgomery_precompute_pkg::N_DEFAULT
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] m,
  output logic [N-1:0] y
);
  logic [N:0] t;
  logic [N:0] m_ext;

  assign t     = {a, 1'b0};
  assign m_ext = {1'b0, m};
  // With a < m, 2a < 2m, so a single conditional subtract is enough.
  assign y = (t >= m_ext) ? N'(t - m_ext) : t[N-1:0];
endmodule

// File: rtl/montgomery_precompute.sv
// Computes R mod M and R^2 mod M (R = 2^N) by 2N iterated modular doublings.
module montgomery_precompute
  import montgomery_precompute_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int CW = CW_DEFAULT
) (
  input  logic                   clk,
  input  logic                   resetn,
  montgomery_precompute_if.slave bus
);
  state_t        state, state_nxt;
  logic [N-1:0]  m_reg, acc, acc_nxt, rmodm_q, r2modm_q;
  logic [CW-1:0] cnt;
  logic          accept, last_step, busy_c, done_c;

  assign accept    = ((state == IDLE) || (state == DONE)) && bus.start;
  assign last_step = (cnt == CW'(2*N-1));

  mod_double #(.N(N)) u_mod_double (
    .a (acc),
    .m (m_reg),
    .y (acc_nxt)
  );

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (bus.start) state_nxt = RUN;
      RUN:        if (last_step) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_c = 1'b0;
    done_c = 1'b0;
    case (state)
      RUN:     busy_c = 1'b1;
      DONE:    done_c = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      m_reg    <= '0;
      acc      <= '0;
      cnt      <= '0;
      rmodm_q  <= '0;
      r2modm_q <= '0;
    end else if (accept) begin
      m_reg <= bus.in_m;
      cnt   <= '0;
      // M==1 starts from 0 so both results come out as 0 mod 1.
      acc   <= (bus.in_m == N'(1)) ? '0 : N'(1);
    end else if (state == RUN) begin
      acc <= acc_nxt;
      cnt <= cnt + 1'b1;
      if (cnt == CW'(N-1)) rmodm_q  <= acc_nxt;
      if (last_step)       r2modm_q <= acc_nxt;
    end
  end

  assign bus.rmodm  = rmodm_q;
  assign bus.r2modm = r2modm_q;
  assign bus.busy   = busy_c;
  assign bus.done   = done_c;
endmodule

// File: tb/tb_montgomery_precompute.sv
// Directed bench for montgomery_precompute at N=8 and N=512.
module tb_montgomery_precompute;
  localparam int BN = 512;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  montgomery_precompute_if #(.N(8))  s_bus ();
  montgomery_precompute_if #(.N(BN)) b_bus ();

  montgomery_precompute #(.N(8), .CW(5)) u_small (
    .clk    (clk),
    .resetn (resetn),
    .bus    (s_bus)
  );

  montgomery_precompute #(.N(BN), .CW(11)) u_big (
    .clk    (clk),
    .resetn (resetn),
    .bus    (b_bus)
  );

  task automatic check(input string tag, input logic [BN-1:0] got, input logic [BN-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [BN-1:0] ref_rmod(input logic [BN-1:0] m);
    logic [2*BN:0] r;
    r = (2*BN+1)'(1) << BN;
    return BN'(r % {{(BN+1){1'b0}}, m});
  endfunction

  function automatic logic [BN-1:0] ref_r2mod(input logic [BN-1:0] m, input logic [BN-1:0] rm);
    logic [2*BN-1:0] p;
    p = {{BN{1'b0}}, rm} * {{BN{1'b0}}, rm};
    return BN'(p % {{BN{1'b0}}, m});
  endfunction

  // Called at posedge+1; returns at the sampling edge k plus 1.
  task automatic pulse_small(input logic [7:0] m, input string tag);
    s_bus.start = 1'b1;
    s_bus.in_m  = m;
    @(posedge clk); #1;
    s_bus.start = 1'b0;
    check({tag, "_done_drop"}, BN'(s_bus.done), BN'(0));
    check({tag, "_busy_rise"}, BN'(s_bus.busy), BN'(1));
  endtask

  task automatic run_small(input logic [7:0] m, input logic [7:0] er, input logic [7:0] er2,
                           input string tag);
    int cyc;
    bit busy_ok;
    pulse_small(m, tag);
    cyc = 0;
    busy_ok = 1'b1;
    while (!s_bus.done && cyc < 40) begin
      if (!s_bus.busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_latency"}, BN'(cyc), BN'(16));
    check({tag, "_busy_window"}, BN'(busy_ok), BN'(1));
    check({tag, "_busy_low"}, BN'(s_bus.busy), BN'(0));
    check({tag, "_rmodm"}, BN'(s_bus.rmodm), BN'(er));
    check({tag, "_r2modm"}, BN'(s_bus.r2modm), BN'(er2));
  endtask

  task automatic run_big(input logic [BN-1:0] m, input logic [BN-1:0] er, input logic [BN-1:0] er2,
                         input string tag);
    int cyc;
    b_bus.start = 1'b1;
    b_bus.in_m  = m;
    @(posedge clk); #1;
    b_bus.start = 1'b0;
    cyc = 0;
    while (!b_bus.done && cyc < 1100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_latency"}, BN'(cyc), BN'(1024));
    check({tag, "_busy_low"}, BN'(b_bus.busy), BN'(0));
    check({tag, "_rmodm"}, b_bus.rmodm, er);
    check({tag, "_r2modm"}, b_bus.r2modm, er2);
  endtask

  initial begin
    int cyc;
    logic [BN-1:0] m, er;

    s_bus.start = 1'b0; s_bus.in_m = '0;
    b_bus.start = 1'b0; b_bus.in_m = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_rmodm",  BN'(s_bus.rmodm),  BN'(0));
    check("rst_s_r2modm", BN'(s_bus.r2modm), BN'(0));
    check("rst_s_busy",   BN'(s_bus.busy),   BN'(0));
    check("rst_s_done",   BN'(s_bus.done),   BN'(0));
    check("rst_b_rmodm",  b_bus.rmodm,       BN'(0));
    check("rst_b_done",   BN'(b_bus.done),   BN'(0));
    resetn = 1'b1;
    @(posedge clk); #1;

    run_small(8'd13,  8'd9, 8'd3, "m13");
    run_small(8'd255, 8'd1, 8'd1, "m255");
    run_small(8'd3,   8'd1, 8'd1, "m3");
    run_small(8'd1,   8'd0, 8'd0, "m1");

    // Second start plus a new in_m mid-run must not restart or change the modulus.
    pulse_small(8'd13, "ign");
    cyc = 0;
    repeat (5) begin @(posedge clk); #1; cyc++; end
    s_bus.start = 1'b1;
    s_bus.in_m  = 8'd7;
    @(posedge clk); #1;
    cyc++;
    s_bus.start = 1'b0;
    check("ign_busy", BN'(s_bus.busy), BN'(1));
    while (!s_bus.done && cyc < 40) begin @(posedge clk); #1; cyc++; end
    check("ign_latency", BN'(cyc), BN'(16));
    check("ign_rmodm",  BN'(s_bus.rmodm),  BN'(9));
    check("ign_r2modm", BN'(s_bus.r2modm), BN'(3));

    // Reset at cycle 10: rmodm has already been captured, so zero proves the clear.
    pulse_small(8'd13, "rst");
    repeat (9) @(posedge clk);
    #1;
    check("rst_mid_rmodm_set", BN'(s_bus.rmodm), BN'(9));
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    check("rst_mid_rmodm",  BN'(s_bus.rmodm),  BN'(0));
    check("rst_mid_r2modm", BN'(s_bus.r2modm), BN'(0));
    check("rst_mid_done",   BN'(s_bus.done),   BN'(0));
    check("rst_mid_busy",   BN'(s_bus.busy),   BN'(0));
    run_small(8'd13, 8'd9, 8'd3, "post_rst");

    run_big({BN{1'b1}}, BN'(1), BN'(1), "big_max");
    for (int i = 0; i < 50; i++) begin
      for (int w = 0; w < BN/32; w++) m[w*32 +: 32] = $urandom;
      m[BN-1] = 1'b1;
      m[0]    = 1'b1;
      er = ref_rmod(m);
      run_big(m, er, ref_r2mod(m, er), $sformatf("big_rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
